// File: rtl/keypad_pkg.sv
// Shared types and bit-vector helpers for the parametrised keypad scanner.
// Helpers work on a fixed 32-bit vector; callers size-cast to their own widths.
package keypad_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_EMIT     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_e;

  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_W-1:0] idx);
    return {{(MAX_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [MAX_W-1:0] onehot_index(input logic [MAX_W-1:0] vec);
    logic [MAX_W-1:0] idx;
    idx = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W; i++) begin
      if (vec[i]) begin
        idx = i[MAX_W-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves something.
  function automatic logic multi_hot(input logic [MAX_W-1:0] vec);
    return (vec & (vec - {{(MAX_W-1){1'b0}}, 1'b1})) != {MAX_W{1'b0}};
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous row lines, cleared by reset.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Metastability chain: first stage may go metastable, second settles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scanner_param.sv
// ROWS x COLS matrix keypad scanner: tick-paced column scan, press/release
// debounce, multi-key rejection and a valid/ready key-code output.
module keypad_scanner_param
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3,
  localparam int CODE_W  = $clog2(ROWS * COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic              multi
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int CIDX_W = $clog2(COLS);
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);

  logic [ROWS-1:0]   rs_s;
  logic [DIV_W-1:0]  div_r;
  logic              tick_s;

  state_e            state_r, state_s;
  logic [CIDX_W-1:0] cidx_r, cidx_s;
  logic [CIDX_W-1:0] ccap_r, ccap_s;
  logic [ROWS-1:0]   rcap_r, rcap_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [CNT_W-1:0]  rel_r, rel_s;
  logic [CODE_W-1:0] code_r, code_s;
  logic              valid_r, valid_s;
  logic              multi_r, multi_s;
  logic [COLS-1:0]   col_r, col_s;

  logic [CNT_W-1:0]  cnt_inc_s;
  logic [CNT_W-1:0]  rel_inc_s;
  logic [CODE_W-1:0] code_scan_s;
  logic [CODE_W-1:0] code_deb_s;

  keypad_sync #(.W(ROWS)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (row),
    .q     (rs_s)
  );

  assign tick_s    = (div_r == DIV_W'(SCAN_DIV - 1));
  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign rel_inc_s = rel_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Code for a capture straight from SCAN and for a completed debounce.
  assign code_scan_s = CODE_W'(onehot_index(MAX_W'(rs_s))) * CODE_W'(COLS) + CODE_W'(cidx_r);
  assign code_deb_s  = CODE_W'(onehot_index(MAX_W'(rcap_r))) * CODE_W'(COLS) + CODE_W'(ccap_r);

  // Free-running scan divider, independent of the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic; only EMIT reacts between ticks.
  always_comb begin
    state_s = state_r;
    cidx_s  = cidx_r;
    ccap_s  = ccap_r;
    rcap_s  = rcap_r;
    cnt_s   = cnt_r;
    rel_s   = rel_r;
    code_s  = code_r;
    valid_s = valid_r;
    multi_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && (rs_s != {ROWS{1'b0}})) begin
          state_s = ST_SCAN;
          cidx_s  = {CIDX_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!tick_s) begin
          state_s = ST_SCAN;
        end else if (rs_s == {ROWS{1'b0}}) begin
          if (cidx_r == CIDX_W'(COLS - 1)) begin
            state_s = ST_IDLE;
          end else begin
            cidx_s = cidx_r + {{(CIDX_W-1){1'b0}}, 1'b1};
          end
        end else if (!multi_hot(MAX_W'(rs_s))) begin
          rcap_s = rs_s;
          ccap_s = cidx_r;
          cnt_s  = {{(CNT_W-1){1'b0}}, 1'b1};
          if (DEBOUNCE == 1) begin
            state_s = ST_EMIT;
            valid_s = 1'b1;
            code_s  = code_scan_s;
          end else begin
            state_s = ST_DEBOUNCE;
          end
        end else begin
          multi_s = 1'b1;
          rel_s   = {CNT_W{1'b0}};
          state_s = ST_RELEASE;
        end
      end
      ST_DEBOUNCE: begin
        if (!tick_s) begin
          state_s = ST_DEBOUNCE;
        end else if (rs_s == rcap_r) begin
          cnt_s = cnt_inc_s;
          if (cnt_inc_s == CNT_W'(DEBOUNCE)) begin
            state_s = ST_EMIT;
            valid_s = 1'b1;
            code_s  = code_deb_s;
          end else begin
            state_s = ST_DEBOUNCE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        // Rows are ignored here so a release under backpressure keeps the event.
        if (valid_r && ready) begin
          valid_s = 1'b0;
          rel_s   = {CNT_W{1'b0}};
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_RELEASE: begin
        if (!tick_s) begin
          state_s = ST_RELEASE;
        end else if (rs_s == {ROWS{1'b0}}) begin
          rel_s = rel_inc_s;
          if (rel_inc_s == CNT_W'(DEBOUNCE)) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RELEASE;
          end
        end else begin
          rel_s = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // Column drive follows the next state so col changes on the same edge.
  always_comb begin
    col_s = {COLS{1'b1}};
    case (state_s)
      ST_IDLE:     col_s = {COLS{1'b1}};
      ST_SCAN:     col_s = COLS'(onehot(MAX_W'(cidx_s)));
      ST_DEBOUNCE: col_s = COLS'(onehot(MAX_W'(ccap_s)));
      ST_EMIT:     col_s = COLS'(onehot(MAX_W'(ccap_s)));
      ST_RELEASE:  col_s = {COLS{1'b1}};
      default:     col_s = {COLS{1'b1}};
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cidx_r  <= {CIDX_W{1'b0}};
      ccap_r  <= {CIDX_W{1'b0}};
      rcap_r  <= {ROWS{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      rel_r   <= {CNT_W{1'b0}};
      code_r  <= {CODE_W{1'b0}};
      valid_r <= 1'b0;
      multi_r <= 1'b0;
      col_r   <= {COLS{1'b1}};
    end else begin
      state_r <= state_s;
      cidx_r  <= cidx_s;
      ccap_r  <= ccap_s;
      rcap_r  <= rcap_s;
      cnt_r   <= cnt_s;
      rel_r   <= rel_s;
      code_r  <= code_s;
      valid_r <= valid_s;
      multi_r <= multi_s;
      col_r   <= col_s;
    end
  end

  assign col   = col_r;
  assign code  = code_r;
  assign valid = valid_r;
  assign multi = multi_r;

endmodule
